// File: rtl/text_pkg.sv
// Shared constants and types for the character-cell text overlay.
package text_pkg;

    localparam int GLYPH_W      = 16;
    localparam int GLYPH_H      = 16;
    localparam int CODE_W       = 5;
    localparam int LETTER_COUNT = 26;

    localparam logic [CODE_W-1:0] BLANK_CODE_DEFAULT = 5'd31;

    // Clear sequencer: CLEAR sweeps the buffer, IDLE accepts host writes.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_t;

    // Address width for a buffer of the given depth (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port RAM, one write and one registered read port.
// A read of the address being written returns the previous contents.
module text_buffer_ram #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and read in the same block so the read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_overlay.sv
// Character-cell text layer: maps the scan position to a buffer cell and a
// glyph pixel, drives the glyph lookup and registers the returned bit.
module text_overlay
    import text_pkg::*;
#(
    parameter int                TEXT_COLS  = 16,
    parameter int                TEXT_ROWS  = 2,
    parameter int                ORIGIN_X   = 64,
    parameter int                ORIGIN_Y   = 32,
    parameter int                SCALE_LOG2 = 0,
    parameter logic [CODE_W-1:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              pix_valid,
    input  logic              wr_en,
    input  logic [4:0]        wr_col,
    input  logic [2:0]        wr_row,
    input  logic [4:0]        wr_char,
    input  logic              clr_req,
    output logic              wr_ready,
    output logic              busy,
    output logic [4:0]        letter_i,
    output logic [3:0]        letter_x,
    output logic [3:0]        letter_y,
    input  logic              glyph_bit,
    output logic              text_pix,
    output logic              text_valid
);

    localparam int DEPTH     = TEXT_COLS * TEXT_ROWS;
    localparam int ADDR_W    = addr_width(DEPTH);
    localparam int GX_W      = $clog2(GLYPH_W);
    localparam int GY_W      = $clog2(GLYPH_H);
    localparam int SHIFT_X   = GX_W + SCALE_LOG2;
    localparam int SHIFT_Y   = GY_W + SCALE_LOG2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // ---------------- pixel pipeline ----------------
    logic [9:0] dx, dy, col_full, row_full;
    logic       in_region;

    assign dx       = pix_x - 10'(ORIGIN_X);
    assign dy       = pix_y - 10'(ORIGIN_Y);
    assign col_full = dx >> SHIFT_X;
    assign row_full = dy >> SHIFT_Y;
    // The origin compares catch the wrapped dx/dy left of or above the region.
    assign in_region = pix_valid
                     & (pix_x >= 10'(ORIGIN_X)) & (pix_y >= 10'(ORIGIN_Y))
                     & (col_full < 10'(TEXT_COLS)) & (row_full < 10'(TEXT_ROWS));

    logic [4:0]      col_e1;
    logic [2:0]      row_e1;
    logic [GX_W-1:0] gx_e1;
    logic [GY_W-1:0] gy_e1;
    logic            in_region_e1, valid_e1;

    // E1: cell coordinates, glyph coordinates and region qualifier.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_e1       <= '0;
            row_e1       <= '0;
            gx_e1        <= '0;
            gy_e1        <= '0;
            in_region_e1 <= 1'b0;
            valid_e1     <= 1'b0;
        end else begin
            col_e1       <= col_full[4:0];
            row_e1       <= row_full[2:0];
            gx_e1        <= GX_W'(dx >> SCALE_LOG2);
            gy_e1        <= GY_W'(dy >> SCALE_LOG2);
            in_region_e1 <= in_region;
            valid_e1     <= pix_valid;
        end
    end

    logic [ADDR_W-1:0] rd_addr;
    logic [CODE_W-1:0] rd_code;
    logic              in_region_e2, valid_e2;

    // Addresses of in-range cells always fit ADDR_W, so modular math is exact.
    assign rd_addr = ADDR_W'(row_e1) * ADDR_W'(TEXT_COLS) + ADDR_W'(col_e1);

    // E2: glyph coordinates and qualifiers alongside the buffer read.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            letter_x     <= '0;
            letter_y     <= '0;
            in_region_e2 <= 1'b0;
            valid_e2     <= 1'b0;
        end else begin
            letter_x     <= gx_e1;
            letter_y     <= gy_e1;
            in_region_e2 <= in_region_e1;
            valid_e2     <= valid_e1;
        end
    end

    // The RAM output is not reset; the qualifier masks it to blank instead.
    assign letter_i = in_region_e2 ? rd_code : BLANK_CODE;

    // E3: registered overlay pixel; codes past the letters are transparent.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            text_pix   <= 1'b0;
            text_valid <= 1'b0;
        end else begin
            text_pix   <= glyph_bit & in_region_e2 & (letter_i < CODE_W'(LETTER_COUNT));
            text_valid <= valid_e2;
        end
    end

    // ---------------- clear sequencer and write port ----------------
    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;
    logic [ADDR_W-1:0] wr_addr, ram_waddr;
    logic [CODE_W-1:0] ram_wdata;
    logic              ram_we, wr_ok;

    assign wr_addr = ADDR_W'(wr_row) * ADDR_W'(TEXT_COLS) + ADDR_W'(wr_col);
    assign wr_ok   = wr_en & wr_ready
                   & ({1'b0, wr_col} < 6'(TEXT_COLS)) & ({1'b0, wr_row} < 4'(TEXT_ROWS));

    // State, sweep address and the registered status flags.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
            busy         <= 1'b1;
            wr_ready     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
            busy         <= (state_next == ST_CLEAR);
            wr_ready     <= (state_next == ST_IDLE);
        end
    end

    // Next state and write-port mux; a clear request beats a same-cycle write.
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        ram_we        = 1'b0;
        ram_waddr     = wr_addr;
        ram_wdata     = wr_char;
        case (state_reg)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr_reg;
                ram_wdata = BLANK_CODE;
                if (clr_addr_reg == LAST_ADDR) begin
                    state_next    = ST_IDLE;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr_reg + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_next    = ST_CLEAR;
                    clr_addr_next = '0;
                end else if (wr_ok) begin
                    ram_we = 1'b1;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    text_buffer_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (CODE_W)
    ) u_buffer (
        .clk    (vga_clk),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr  (rd_addr),
        .rdata  (rd_code)
    );

endmodule

// File: tb/tb_text_overlay.sv
// Scoreboard bench for text_overlay: stimulus queues expected lookup and
// pixel responses, a negedge monitor retires them when they fall due.
module tb_text_overlay;

    logic       vga_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [9:0] pix_x = '0, pix_y = '0;
    logic       pix_valid = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_col = '0;
    logic [2:0] wr_row = '0;
    logic [4:0] wr_char = '0;
    logic       clr_req = 1'b0;
    logic       force_glyph = 1'b0;

    logic       wr_ready, busy, text_pix, text_valid, glyph_bit;
    logic [4:0] letter_i;
    logic [3:0] letter_x, letter_y;

    logic       s1_wr_ready, s1_busy, s1_text_pix, s1_text_valid, s1_glyph_bit;
    logic [4:0] s1_letter_i;
    logic [3:0] s1_letter_x, s1_letter_y;

    // Glyph model: parity of the low bits, or all-ones when forced.
    assign glyph_bit    = force_glyph | (letter_i[0] ^ letter_x[0] ^ letter_y[0]);
    assign s1_glyph_bit = s1_letter_i[0] ^ s1_letter_x[0] ^ s1_letter_y[0];

    text_overlay dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char),
        .clr_req(clr_req), .wr_ready(wr_ready), .busy(busy),
        .letter_i(letter_i), .letter_x(letter_x), .letter_y(letter_y),
        .glyph_bit(glyph_bit), .text_pix(text_pix), .text_valid(text_valid)
    );

    text_overlay #(.SCALE_LOG2(1)) dut_s1 (
        .vga_clk(vga_clk), .sys_rst(sys_rst),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char),
        .clr_req(clr_req), .wr_ready(s1_wr_ready), .busy(s1_busy),
        .letter_i(s1_letter_i), .letter_x(s1_letter_x), .letter_y(s1_letter_y),
        .glyph_bit(s1_glyph_bit), .text_pix(s1_text_pix), .text_valid(s1_text_valid)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int tag_id = 0;

    // kind 0: main lookup outputs, 1: main pixel outputs, 2: scaled lookup outputs
    typedef struct {
        int due;
        int kind;
        int id;
        int code;
        int gx;
        int gy;
        int pix;
        int valid;
        bit chk_xy;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: retire every expectation that falls due on this cycle.
    always @(negedge vga_clk) begin
        int i;
        exp_t e;
        i = 0;
        while (i < sb.size()) begin
            e = sb[i];
            if (e.due == cyc) begin
                case (e.kind)
                    0: begin
                        check($sformatf("letter_i#%0d", e.id), int'(letter_i), e.code);
                        if (e.chk_xy) begin
                            check($sformatf("letter_x#%0d", e.id), int'(letter_x), e.gx);
                            check($sformatf("letter_y#%0d", e.id), int'(letter_y), e.gy);
                        end
                    end
                    1: begin
                        check($sformatf("text_pix#%0d", e.id), int'(text_pix), e.pix);
                        check($sformatf("text_valid#%0d", e.id), int'(text_valid), e.valid);
                    end
                    default: begin
                        check($sformatf("s1_letter_i#%0d", e.id), int'(s1_letter_i), e.code);
                        check($sformatf("s1_letter_x#%0d", e.id), int'(s1_letter_x), e.gx);
                        check($sformatf("s1_letter_y#%0d", e.id), int'(s1_letter_y), e.gy);
                    end
                endcase
                sb.delete(i);
            end else if (e.due < cyc) begin
                check($sformatf("sb_overdue#%0d", e.id), cyc, e.due);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic drain();
        repeat (5) tick();
    endtask

    // Drive one pixel and queue its lookup (2 edges) and pixel (3 edges) results.
    task automatic pix(input int x, input int y, input bit v, input int code,
                       input int gx, input int gy, input int epix, input bit chk_xy);
        exp_t e;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        pix_valid = v;
        tag_id++;
        e.id = tag_id; e.code = code; e.gx = gx; e.gy = gy;
        e.pix = epix; e.valid = int'(v); e.chk_xy = chk_xy;
        e.due = cyc + 2; e.kind = 0; sb.push_back(e);
        e.due = cyc + 3; e.kind = 1; sb.push_back(e);
        tick();
    endtask

    // Queue a lookup expectation for the scaled instance on the next pixel.
    task automatic s1_expect(input int code, input int gx, input int gy);
        exp_t e;
        e.id = tag_id + 1; e.code = code; e.gx = gx; e.gy = gy;
        e.pix = 0; e.valid = 0; e.chk_xy = 1'b1;
        e.due = cyc + 2; e.kind = 2; sb.push_back(e);
    endtask

    task automatic wr(input int c, input int r, input int ch);
        wr_en   = 1'b1;
        wr_col  = 5'(c);
        wr_row  = 3'(r);
        wr_char = 5'(ch);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},       int'(busy), 1);
        check({tag, "_wr_ready"},   int'(wr_ready), 0);
        check({tag, "_letter_i"},   int'(letter_i), 31);
        check({tag, "_letter_x"},   int'(letter_x), 0);
        check({tag, "_letter_y"},   int'(letter_y), 0);
        check({tag, "_text_pix"},   int'(text_pix), 0);
        check({tag, "_text_valid"}, int'(text_valid), 0);
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_busy_cycles"}, n, 32);
        check({tag, "_wr_ready"}, int'(wr_ready), 1);
    endtask

    int scan_y[5] = '{32, 39, 47, 48, 63};

    initial begin
        // Reset and initial clear.
        #1 sys_rst = 1'b1;
        repeat (3) tick();
        check_reset("rst0");
        sys_rst = 1'b0;
        count_busy("clear0");

        // Whole-region scan over a freshly cleared buffer, glyph forced on.
        force_glyph = 1'b1;
        foreach (scan_y[k]) begin
            for (int x = 64; x < 320; x++) begin
                pix(x, scan_y[k], 1'b1, 31, (x - 64) % 16, (scan_y[k] - 32) % 16, 0, 1'b1);
            end
        end
        drain();
        force_glyph = 1'b0;

        // Write a letter and hit one foreground and one background glyph pixel.
        wr(3, 0, 7);
        pix(117, 41, 1'b1, 7, 5, 9, 1, 1'b1);
        pix(116, 41, 1'b1, 7, 4, 9, 0, 1'b1);
        drain();

        // Outside the region and invalid pixels stay blank even with glyph forced.
        force_glyph = 1'b1;
        pix(116, 41, 1'b1, 7, 4, 9, 1, 1'b1);
        pix(63, 41, 1'b1, 31, 15, 9, 0, 1'b1);
        pix(100, 64, 1'b1, 31, 4, 0, 0, 1'b1);
        pix(117, 41, 1'b0, 31, 5, 9, 0, 1'b1);
        pix(70, 33, 1'b1, 31, 6, 1, 0, 1'b1);
        drain();

        // Transparent code and dropped out-of-range writes.
        wr(0, 1, 28);
        pix(64, 48, 1'b1, 28, 0, 0, 0, 1'b1);
        pix(79, 63, 1'b1, 28, 15, 15, 0, 1'b1);
        wr(16, 0, 5);
        wr(0, 2, 9);
        wr(31, 7, 1);
        pix(64, 48, 1'b1, 28, 0, 0, 0, 1'b1);
        pix(64, 32, 1'b1, 31, 0, 0, 0, 1'b1);
        drain();
        force_glyph = 1'b0;

        // Write landing on the same edge as the read of that cell.
        pix(117, 41, 1'b1, 7, 5, 9, 1, 1'b1);
        wr_en = 1'b1; wr_col = 5'd3; wr_row = 3'd0; wr_char = 5'd2;
        pix(0, 0, 1'b0, 31, 0, 0, 0, 1'b0);
        wr_en = 1'b0;
        tick();
        pix(117, 41, 1'b1, 2, 5, 9, 0, 1'b1);

        // Double-size instance sharing the same writes.
        s1_expect(31, 1, 0);
        pix(99, 32, 1'b1, 31, 3, 0, 0, 1'b1);
        s1_expect(31, 3, 0);
        pix(134, 65, 1'b1, 31, 6, 1, 0, 1'b1);
        s1_expect(2, 3, 0);
        pix(166, 33, 1'b1, 31, 6, 1, 0, 1'b1);
        drain();

        // Clear beats a same-cycle write; a repeat request mid-clear is ignored.
        clr_req = 1'b1;
        wr_en = 1'b1; wr_col = 5'd5; wr_row = 3'd0; wr_char = 5'd3;
        tick();
        clr_req = 1'b0;
        wr_en = 1'b0;
        begin
            int n;
            n = 0;
            while (busy && n < 200) begin
                clr_req = (n == 5);
                tick();
                n++;
            end
            clr_req = 1'b0;
            check("clr_busy_cycles", n, 32);
        end
        pix(117, 41, 1'b1, 31, 5, 9, 0, 1'b1);
        pix(64, 48, 1'b1, 31, 0, 0, 0, 1'b1);
        pix(144, 32, 1'b1, 31, 0, 0, 0, 1'b1);
        drain();

        // Reset in the middle of a clear.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        pix_x = 10'd117; pix_y = 10'd41; pix_valid = 1'b1;
        repeat (9) tick();
        check("pre_rst_letter_x", int'(letter_x), 5);
        check("pre_rst_text_valid", int'(text_valid), 1);
        sys_rst = 1'b1;
        #1;
        check_reset("rst_mid");
        pix_valid = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
        count_busy("clear_after_rst");

        drain();
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/text_overlay.md
Name: text_overlay

Overview:
- Character-cell text layer for the VGA video path. It holds a small writable text buffer of glyph codes.
- For each scan position it works out which cell and which glyph pixel is being drawn. It drives the letter glyph lookup with (code, glyph x, glyph y) and registers the returned pixel bit as an overlay pixel.
- Acts as the initiator/consumer side of the combinational glyph lookup. It sits between the VGA timing generator and the pixel mux.

Parameters:
- TEXT_COLS, 16, number of character columns (1..32).
- TEXT_ROWS, 2, number of character rows (1..8).
- ORIGIN_X, 64, left edge of the text region in pixels.
- ORIGIN_Y, 32, top edge of the text region in pixels.
- SCALE_LOG2, 0, glyph magnification of 2^SCALE_LOG2 (0..2); cell size is 16<<SCALE_LOG2 pixels.
- BLANK_CODE, 31, code written by clear; it is always transparent.

Ports:
- vga_clk  in  1  pixel clock; all logic is on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- pix_x  in  10  current scan x.
- pix_y  in  10  current scan y.
- pix_valid  in  1  active-video qualifier.
- wr_en  in  1  buffer write strobe.
- wr_col  in  5  write column.
- wr_row  in  3  write row.
- wr_char  in  5  glyph code to write (0..25 are valid letters).
- clr_req  in  1  single-cycle pulse requesting a clear of the whole buffer.
- wr_ready  out  1  high when writes are accepted.
- busy  out  1  high while a clear is in progress.
- letter_i  out  5  glyph code sent to the lookup.
- letter_x  out  4  glyph column sent to the lookup.
- letter_y  out  4  glyph row sent to the lookup.
- glyph_bit  in  1  lookup result; combinational from letter_i/letter_x/letter_y in the same cycle.
- text_pix  out  1  overlay pixel (1 = foreground).
- text_valid  out  1  pix_valid delayed to align with text_pix.

Behaviour:
- Reset values: wr_ready=0, busy=1, letter_i=BLANK_CODE, letter_x=0, letter_y=0, text_pix=0, text_valid=0.
- Pipeline stage E1 registers the following (dx = pix_x-ORIGIN_X, dy = pix_y-ORIGIN_Y, unsigned 10-bit):
  - col = dx>>(4+SCALE_LOG2) and row = dy>>(4+SCALE_LOG2).
  - gx = (dx>>SCALE_LOG2)[3:0] and gy = (dy>>SCALE_LOG2)[3:0].
  - in_region = pix_valid & pix_x>=ORIGIN_X & pix_y>=ORIGIN_Y & col<TEXT_COLS & row<TEXT_ROWS.
- Stage E2 does a synchronous buffer read at address row*TEXT_COLS+col.
  - letter_i = stored code if in_region, else BLANK_CODE.
  - letter_x and letter_y take the registered gx and gy.
- Stage E3 registers text_pix = glyph_bit & in_region_d & (letter_i<=25), and registers text_valid.
- Latency: inputs sampled at edge n appear on text_pix/text_valid after edge n+3. Throughput is one pixel per clock with no stalls.
- The buffer is an inferred RAM of TEXT_COLS*TEXT_ROWS x 5 bits with no reset. It has one write port and one read port, and reads return the old data (read-first).
- Write rule: a write is accepted when wr_en & wr_ready & wr_col<TEXT_COLS & wr_row<TEXT_ROWS. Out-of-range writes are dropped silently.
- A write to the cell currently being read: the read in that cycle returns the old code.
- Clear FSM has states CLEAR and IDLE.
  - Reset enters CLEAR with clr_addr=0.
  - CLEAR writes BLANK_CODE at clr_addr, then increments it. After the final address it goes to IDLE. A clear therefore takes exactly TEXT_COLS*TEXT_ROWS cycles.
  - In CLEAR: busy=1 and wr_ready=0. In IDLE: busy=0 and wr_ready=1; both are registered outputs.
  - IDLE and clr_req=1 goes to CLEAR with clr_addr=0. If wr_en is asserted in the same cycle, the write is dropped (clear wins).
  - clr_req during CLEAR is ignored and does not restart the clear.
  - Reset asserted mid-clear returns all registers to reset values immediately. After release the clear restarts from address 0.
- The pixel pipeline keeps running during a clear. Cells not yet cleared may display stale codes; this is permitted.
- Codes 26..31 are transparent regardless of glyph_bit.

Decomposition:
- Shared package text_pkg holds: GLYPH_W=16, GLYPH_H=16, CODE_W=5, LETTER_COUNT=26, BLANK_CODE default, and the FSM state encoding.
- One sub-module, text_buffer_ram: a parameterised read-first synchronous dual-port RAM. The FSM and pipeline stay in text_overlay.

Test Plan:
1. Release reset -> busy=1 and wr_ready=0 for exactly 32 cycles, then busy=0 and wr_ready=1. A scan across the whole region then gives text_pix=0 throughout.
2. Write col=3, row=0, code=7, then drive pix_x=117, pix_y=41, pix_valid=1 (glyph model returns 1 for (7,5,9)) -> 2 cycles later letter_i=7, letter_x=5, letter_y=9. 3 cycles later text_pix=1 and text_valid=1.
3. pix_x=63, or pix_y=64 (row 2), with glyph_bit forced to 1 -> letter_i=31 and text_pix=0. With pix_valid=0 -> text_valid=0 and text_pix=0.
4. Write code 28 to col 0, row 1 and scan it with glyph_bit=1 -> text_pix=0. Write col=16 -> the buffer is unchanged.
5. Write code 2 to a cell in the same cycle its address is read (old code 7) -> letter_i=7 on that pass and 2 on the next pass. SCALE_LOG2=1: pix_x=64+35 -> col 1, letter_x=1.
6. clr_req and wr_en in the same cycle -> the write is dropped and busy=1 for 32 cycles. Assert sys_rst at clear cycle 10 -> outputs go to reset values at once, and after release busy stays high for a full 32 cycles.
